// File: rtl/lu_pkg.sv
// lu_pkg: shared op-code encoding for the pipelined logic unit.
// Contents: op-code width and the eight op-code values.
// op[2]=0 codes keep the encoding of the earlier 2-bit logic unit.
package lu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOR   = 3'b000;
  localparam logic [OP_W-1:0] OP_OR    = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_AND   = 3'b100;
  localparam logic [OP_W-1:0] OP_NAND  = 3'b101;
  localparam logic [OP_W-1:0] OP_NOTA  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASSB = 3'b111;

endpackage

// File: rtl/lu_core_comb.sv
// lu_core_comb: combinational bitwise op mux over WIDTH bits, zero latency.
// Ports: a, b operands; op select; f result; zero (f==0); parity (XOR of f).
// No storage and no handshake; the caller registers the outputs.
module lu_core_comb
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             parity
);

  logic [WIDTH-1:0] w_f;

  always_comb begin
    w_f = '0;
    case (op)
      OP_NOR:   w_f = ~(a | b);
      OP_OR:    w_f = a | b;
      OP_XOR:   w_f = a ^ b;
      OP_XNOR:  w_f = ~(a ^ b);
      OP_AND:   w_f = a & b;
      OP_NAND:  w_f = ~(a & b);
      OP_NOTA:  w_f = ~a;
      OP_PASSB: w_f = b;
      default:  w_f = '0;
    endcase
  end

  assign f      = w_f;
  assign zero   = (w_f == '0);
  assign parity = ^w_f;

endmodule

// File: rtl/lu_pipe_acc.sv
// lu_pipe_acc: registered WIDTH-bit logic unit with accumulator and op counter, 1-cycle latency.
// Ports: in_valid/in_ready + a, b, op, use_acc, acc_wr, acc_clr in; out_valid/out_ready + result, zero, parity out; acc, op_count status.
// in_ready = !out_valid || out_ready (no skid buffer); a stalled result holds until taken.
module lu_pipe_acc
  import lu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             use_acc,
  input  logic             acc_wr,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_parity;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_f;
  logic             w_zero;
  logic             w_parity;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  // Operand B sees the accumulator as it was before this edge, even when
  // the same beat rewrites or clears it.
  assign w_b        = use_acc ? r_acc : b;

  lu_core_comb #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (w_b),
    .op     (op),
    .f      (w_f),
    .zero   (w_zero),
    .parity (w_parity)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_parity    <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_result    <= w_f;
        r_zero      <= w_zero;
        r_parity    <= w_parity;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      // Clear beats a same-cycle write-back.
      if (acc_clr) begin
        r_acc <= '0;
      end else if (w_accept && acc_wr) begin
        r_acc <= w_f;
      end

      // Saturate rather than wrap.
      if (w_accept && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign parity    = r_parity;
  assign acc       = r_acc;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_lu_pipe_acc.sv
// tb_lu_pipe_acc: directed scenarios plus random traffic against a behavioural model.
// Two instances share stimulus: default CNT_W=16 and CNT_W=2 for counter saturation.
// Outputs are checked at the falling edge; in_ready is checked 1 time unit after inputs change.
module tb_lu_pipe_acc;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         use_acc, acc_wr, acc_clr, out_ready;

  logic         in_ready, out_valid, zero, parity;
  logic [W-1:0] result, acc;
  logic [15:0]  op_count;

  logic         in_ready2, out_valid2, zero2, parity2;
  logic [W-1:0] result2, acc2;
  logic [1:0]   op_count2;

  always #5 clk = ~clk;

  lu_pipe_acc #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .use_acc(use_acc), .acc_wr(acc_wr), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .parity(parity), .acc(acc), .op_count(op_count)
  );

  lu_pipe_acc #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .use_acc(use_acc), .acc_wr(acc_wr), .acc_clr(acc_clr),
    .out_valid(out_valid2), .out_ready(out_ready), .result(result2),
    .zero(zero2), .parity(parity2), .acc(acc2), .op_count(op_count2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state.
  logic         m_ov;
  logic [W-1:0] m_res;
  logic [W-1:0] m_acc;
  int           m_cnt;

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [2:0] o);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      case (o)
        3'd0: r[i] = !(x[i] || y[i]);
        3'd1: r[i] = x[i] || y[i];
        3'd2: r[i] = x[i] != y[i];
        3'd3: r[i] = x[i] == y[i];
        3'd4: r[i] = x[i] && y[i];
        3'd5: r[i] = !(x[i] && y[i]);
        3'd6: r[i] = !x[i];
        default: r[i] = y[i];
      endcase
    end
    return r;
  endfunction

  task automatic check_outputs();
    int c2;
    c2 = (m_cnt > 3) ? 3 : m_cnt;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("result",    32'(result),    32'(m_res));
    chk("zero",      32'(zero),      32'(m_res == 0));
    chk("parity",    32'(parity),    32'($countones(m_res) % 2));
    chk("acc",       32'(acc),       32'(m_acc));
    chk("op_count",  32'(op_count),  32'(m_cnt));
    chk("op_count_sat", 32'(op_count2), 32'(c2));
  endtask

  // Called at a falling edge: drive one cycle of inputs, check in_ready,
  // advance the model across the next rising edge and check at the next falling edge.
  task automatic cycle(input logic iv, input logic ordy, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic [2:0] iop, input logic ua,
                       input logic wr, input logic clr, input logic rs);
    logic         exp_rdy, acc_ok;
    logic [W-1:0] bp, r;
    in_valid = iv; out_ready = ordy; a = ia; b = ib; op = iop;
    use_acc = ua; acc_wr = wr; acc_clr = clr; rst = rs;
    #1;
    exp_rdy = !m_ov || ordy;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc_ok = iv && exp_rdy;
    bp = ua ? m_acc : ib;
    r  = ref_op(ia, bp, iop);
    if (rs) begin
      m_ov = 1'b0; m_res = '0; m_acc = '0; m_cnt = 0;
    end else begin
      if (acc_ok) begin
        m_res = r; m_ov = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      if (clr) m_acc = '0;
      else if (acc_ok && wr) m_acc = r;
    end
    @(negedge clk);
    check_outputs();
  endtask

  logic [W-1:0] t1_tbl [8];

  initial begin
    t1_tbl[0] = 8'hC0; t1_tbl[1] = 8'h3F; t1_tbl[2] = 8'h33; t1_tbl[3] = 8'hCC;
    t1_tbl[4] = 8'h0C; t1_tbl[5] = 8'hF3; t1_tbl[6] = 8'hF0; t1_tbl[7] = 8'h3C;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    use_acc = 1'b0; acc_wr = 1'b0; acc_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    m_ov = 1'b0; m_res = '0; m_acc = '0; m_cnt = 0;
    check_outputs();
    rst = 1'b0;

    // 1: op sweep, back-to-back.
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 8'h0F, 8'h3C, 3'(i), 0, 0, 0, 0);
      chk("t1_table", 32'(result), 32'(t1_tbl[i]));
    end
    chk("t1_count", 32'(op_count), 32'd8);
    cycle(0, 1, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0);

    // 2: backpressure, then consume-and-accept in one cycle.
    cycle(1, 0, 8'h5A, 8'h0F, 3'd1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'hFF, 8'hFF, 3'd4, 0, 0, 0, 0);
    chk("t2_hold", 32'(result), 32'h5F);
    cycle(1, 1, 8'h81, 8'h00, 3'd6, 0, 0, 0, 0);
    chk("t2_new", 32'(result), 32'h7E);

    // 3: accumulator chain.
    cycle(0, 1, 8'h00, 8'h00, 3'd0, 0, 0, 1, 0);
    cycle(1, 1, 8'hAA, 8'h55, 3'd7, 0, 1, 0, 0);
    chk("t3_acc55", 32'(acc), 32'h55);
    cycle(1, 1, 8'hFF, 8'h00, 3'd2, 1, 1, 0, 0);
    chk("t3_res", 32'(result), 32'hAA);
    chk("t3_acc", 32'(acc), 32'hAA);

    // 4: use_acc reads old acc while clr beats wr.
    cycle(1, 1, 8'h00, 8'h12, 3'd7, 0, 1, 0, 0);
    cycle(1, 1, 8'h01, 8'h00, 3'd1, 1, 1, 1, 0);
    chk("t4_res", 32'(result), 32'h13);
    chk("t4_acc", 32'(acc), 32'h00);

    // 5: zero result; saturation on the CNT_W=2 instance.
    cycle(1, 1, 8'hFF, 8'h00, 3'd4, 0, 0, 0, 0);
    chk("t5_zero", 32'(zero), 32'd1);
    chk("t5_sat", 32'(op_count2), 32'd3);

    // 6: reset during a stall.
    cycle(1, 1, 8'h00, 8'h77, 3'd7, 0, 1, 0, 0);
    cycle(1, 0, 8'h33, 8'h00, 3'd6, 0, 0, 0, 0);
    cycle(1, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 1);
    chk("t6_ov", 32'(out_valid), 32'd0);
    chk("t6_acc", 32'(acc), 32'd0);
    cycle(0, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(3) != 0), ($urandom_range(2) != 0),
            W'($urandom), W'($urandom), 3'($urandom),
            $urandom_range(1) == 1, $urandom_range(1) == 1,
            $urandom_range(7) == 0, $urandom_range(63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit=100000");
    $fatal(1);
  end

endmodule
